// File: rtl/round_key_store.sv
// round_key_store: drives an external key_schedule to expand a master key into
// NR_ROUNDS round keys. It keeps the k0 half of each key in a local store and
// replays the keys in reverse order (idx NR_ROUNDS-1 down to 0) over valid/ready.
// Optional feature: define ROUND_KEY_STORE_TIMEOUT_EN to add a watchdog on WAIT_KS.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_IDLE    | store invalid, waiting for start
//   S_ISSUE   | one-cycle ks_start pulse for round ctr
//   S_WAIT_KS | waiting for key_schedule to report finished
//   S_READY   | all round keys valid, waiting for stream_start or start
//   S_STREAM  | presenting rk[idx] until handshake, idx counting down
//
// Widths come from the cipher settings macros. The defaults below are used
// when the settings have not been included ahead of this file.
`ifndef BLOCK_SIZE
`define BLOCK_SIZE 64
`endif
`ifndef KEY_SIZE
`define KEY_SIZE 128
`endif

module round_key_store #(
  parameter int NR_ROUNDS = 32
`ifdef ROUND_KEY_STORE_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 15
`endif
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [`KEY_SIZE-1:0]         key,
  output logic [`KEY_SIZE-1:0]         ks_key,
  output logic [`BLOCK_SIZE-1:0]       ks_round_ctr,
  output logic                         ks_start,
  input  logic [`KEY_SIZE-1:0]         ks_out_key,
  input  logic                         ks_finished,
  output logic                         busy,
  output logic                         keys_ready,
  input  logic                         stream_start,
  output logic                         rk_valid,
  input  logic                         rk_ready,
  output logic [`BLOCK_SIZE-1:0]       rk_data,
  output logic [$clog2(NR_ROUNDS)-1:0] rk_idx,
  output logic                         rk_last,
  output logic                         error
);

  localparam int BW = `BLOCK_SIZE;
  localparam int IW = $clog2(NR_ROUNDS);
  localparam logic [IW-1:0] CTR_LAST = IW'(NR_ROUNDS - 2);
  localparam logic [IW-1:0] IDX_TOP  = IW'(NR_ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_KS,
    S_READY,
    S_STREAM
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ctr;
  logic [IW-1:0] idx;
  logic [BW-1:0] rk_mem [NR_ROUNDS];

  logic load_key;
  logic store_ks;
  logic ctr_inc;
  logic ready_set;
  logic stream_go;
  logic idx_dec;

`ifdef ROUND_KEY_STORE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;
  logic            error_q;
`endif

  // next-state and per-cycle control strobes
  always_comb begin
    state_nxt = state;
    load_key  = 1'b0;
    store_ks  = 1'b0;
    ctr_inc   = 1'b0;
    ready_set = 1'b0;
    stream_go = 1'b0;
    idx_dec   = 1'b0;
`ifdef ROUND_KEY_STORE_TIMEOUT_EN
    wd_expire = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          load_key  = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT_KS;
      S_WAIT_KS: begin
        if (ks_finished) begin
          store_ks = 1'b1;
          if (ctr == CTR_LAST) begin
            ready_set = 1'b1;
            state_nxt = S_READY;
          end else begin
            ctr_inc   = 1'b1;
            state_nxt = S_ISSUE;
          end
        end
`ifdef ROUND_KEY_STORE_TIMEOUT_EN
        else if (wd_cnt == WD_W'(1)) begin
          wd_expire = 1'b1;
          state_nxt = S_IDLE;
        end
`endif
      end
      S_READY: begin
        // a new key takes priority over replaying the old one
        if (start) begin
          load_key  = 1'b1;
          state_nxt = S_ISSUE;
        end else if (stream_start) begin
          stream_go = 1'b1;
          state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (rk_ready) begin
          if (idx == '0) state_nxt = S_READY;
          else           idx_dec   = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // state, round counter, stream index and key_schedule input register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ctr        <= '0;
      idx        <= '0;
      ks_key     <= '0;
      keys_ready <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_key) begin
        ks_key     <= key;
        ctr        <= '0;
        keys_ready <= 1'b0;
      end
      if (store_ks)  ks_key     <= ks_out_key;
      if (ctr_inc)   ctr        <= ctr + IW'(1);
      if (ready_set) keys_ready <= 1'b1;
      if (stream_go) idx        <= IDX_TOP;
      if (idx_dec)   idx        <= idx - IW'(1);
    end
  end

  // round key store; no reset needed since reads are masked outside S_STREAM
  always_ff @(posedge clk) begin
    if (load_key) rk_mem[0]            <= key[BW-1:0];
    if (store_ks) rk_mem[ctr + IW'(1)] <= ks_out_key[BW-1:0];
  end

`ifdef ROUND_KEY_STORE_TIMEOUT_EN
  // watchdog down-counter armed in S_ISSUE so error lands TIMEOUT_CYCLES after it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      error_q <= 1'b0;
    end else begin
      if (state == S_ISSUE)                         wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
      else if (state == S_WAIT_KS && wd_cnt != '0)  wd_cnt <= wd_cnt - WD_W'(1);
      if (load_key)       error_q <= 1'b0;
      else if (wd_expire) error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign ks_start     = (state == S_ISSUE);
  assign busy         = (state == S_ISSUE) || (state == S_WAIT_KS);
  assign ks_round_ctr = BW'(ctr);
  assign rk_valid     = (state == S_STREAM);
  assign rk_data      = rk_valid ? rk_mem[idx] : '0;
  assign rk_idx       = idx;
  assign rk_last      = rk_valid && (idx == '0);

endmodule

// File: tb/tb_round_key_store.sv
// tb_round_key_store: directed bench for round_key_store. A behavioural
// Speck128/128 key_schedule answers ks_start two cycles later, and the bench
// builds the expected round keys from its own software model.
module tb_round_key_store;

  localparam int NR = 32;
  localparam logic [127:0] KEY_A = 128'h0f0e0d0c0b0a0908_0706050403020100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] ks_key;
  logic [63:0]  ks_round_ctr;
  logic         ks_start;
  logic [127:0] ks_out_key = '0;
  logic         ks_finished = 1'b0;
  logic         busy;
  logic         keys_ready;
  logic         stream_start = 1'b0;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic [63:0]  rk_data;
  logic [4:0]   rk_idx;
  logic         rk_last;
  logic         error;

  int           n_chk = 0;
  int           n_pass = 0;
  int           n_fin = 0;
  int           n_kss = 0;
  bit           ks_hold = 1'b0;
  logic [63:0]  exp_rk [NR];
  logic [63:0]  last_beat = '0;

  always #5 clk = ~clk;

  round_key_store dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .key          (key),
    .ks_key       (ks_key),
    .ks_round_ctr (ks_round_ctr),
    .ks_start     (ks_start),
    .ks_out_key   (ks_out_key),
    .ks_finished  (ks_finished),
    .busy         (busy),
    .keys_ready   (keys_ready),
    .stream_start (stream_start),
    .rk_valid     (rk_valid),
    .rk_ready     (rk_ready),
    .rk_data      (rk_data),
    .rk_idx       (rk_idx),
    .rk_last      (rk_last),
    .error        (error)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // one Speck128/128 key-schedule round: l = (ror8(l) + k) ^ i; k = rol3(k) ^ l
  function automatic logic [127:0] ks_step(input logic [127:0] k, input logic [63:0] i);
    logic [63:0] l;
    logic [63:0] r;
    l = k[127:64];
    r = k[63:0];
    l = ({l[7:0], l[63:8]} + r) ^ i;
    r = {r[60:0], r[63:61]} ^ l;
    return {l, r};
  endfunction

  task automatic build_exp(input logic [127:0] mk);
    logic [127:0] k;
    k = mk;
    exp_rk[0] = mk[63:0];
    for (int i = 1; i < NR; i++) begin
      k = ks_step(k, 64'(i - 1));
      exp_rk[i] = k[63:0];
    end
  endtask

  // behavioural key_schedule: answers each ks_start two cycles later
  initial begin : ks_model
    logic [127:0] k;
    logic [63:0]  rc;
    forever begin
      @(posedge clk);
      #1;
      ks_finished = 1'b0;
      if (ks_start) begin
        n_kss++;
        if (!ks_hold) begin
          k  = ks_key;
          rc = ks_round_ctr;
          repeat (2) @(posedge clk);
          #1;
          ks_out_key  = ks_step(k, rc);
          ks_finished = 1'b1;
          n_fin++;
        end
      end
    end
  end

  task automatic pulse_start(input logic [127:0] k);
    @(negedge clk);
    key   = k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // expand a key; with disturb set, junk start/stream_start pulses are thrown in
  task automatic expand(input logic [127:0] k, input bit disturb);
    int f0;
    int s0;
    int cyc;
    build_exp(k);
    f0 = n_fin;
    s0 = n_kss;
    pulse_start(k);
    check("busy_after_start", busy, 1);
    check("ks_start_pulse", ks_start, 1);
    check("ks_round_ctr_first", ks_round_ctr, 0);
    check("ks_key_latched", ks_key, k);
    check("keys_ready_cleared", keys_ready, 0);
    for (cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (keys_ready) break;
      start = disturb && (cyc % 7 == 3);
      if (start) key = ~k;
      stream_start = disturb && (cyc % 11 == 5);
    end
    start        = 1'b0;
    stream_start = 1'b0;
    check("keys_ready", keys_ready, 1);
    check("ks_finished_count", n_fin - f0, NR - 1);
    check("ks_start_count", n_kss - s0, NR - 1);
    check("busy_in_ready", busy, 0);
  endtask

  task automatic run_stream(input bit rnd);
    int          exp_idx;
    int          cyc;
    bit          stalled;
    bit          rdy;
    logic [63:0] sd;
    logic [4:0]  si;
    exp_idx = NR - 1;
    stalled = 1'b0;
    sd      = '0;
    si      = '0;
    @(negedge clk);
    stream_start = 1'b1;
    @(negedge clk);
    stream_start = 1'b0;
    for (cyc = 0; cyc < 400 && exp_idx >= 0; cyc++) begin
      check("rk_valid", rk_valid, 1);
      if (stalled) begin
        check("stall_data", rk_data, sd);
        check("stall_idx", rk_idx, si);
      end
      rdy      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rk_ready = rdy;
      if (rdy) begin
        check("rk_data", rk_data, exp_rk[exp_idx]);
        check("rk_idx", rk_idx, exp_idx[4:0]);
        check("rk_last", rk_last, exp_idx == 0);
        last_beat = rk_data;
        exp_idx--;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        sd      = rk_data;
        si      = rk_idx;
      end
      @(negedge clk);
    end
    rk_ready = 1'b0;
    if (!rnd) check("stream_cycles", cyc, NR);
    check("beats_left", exp_idx + 1, 0);
    check("rk_valid_after", rk_valid, 0);
    check("rk_last_after", rk_last, 0);
  endtask

  initial begin : main
    int cyc;
    int n;
    int s0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_keys_ready", keys_ready, 0);
    check("rst_rk_valid", rk_valid, 0);
    check("rst_rk_last", rk_last, 0);
    check("rst_rk_data", rk_data, 0);
    check("rst_rk_idx", rk_idx, 0);
    check("rst_ks_start", ks_start, 0);
    check("rst_ks_key", ks_key, 0);
    check("rst_ks_round_ctr", ks_round_ctr, 0);
    check("rst_error", error, 0);
    rst_n = 1'b1;

    // basic expansion and full-rate stream
    expand(KEY_A, 1'b0);
    run_stream(1'b0);
    check("last_beat_hand", last_beat, 64'h0706050403020100);

    // random backpressure
    run_stream(1'b1);

    // re-streaming does not re-run the key schedule
    s0 = n_kss;
    run_stream(1'b0);
    run_stream(1'b0);
    check("restream_no_ks_start", n_kss - s0, 0);
    check("restream_keys_ready", keys_ready, 1);

    // start/stream_start while busy are ignored
    expand(KEY_A, 1'b1);
    run_stream(1'b0);

    // reset in the middle of expansion, then a fresh all-zero key
    pulse_start(128'h1122334455667788_99aabbccddeeff00);
    for (cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      if (ks_start && ks_round_ctr == 64'd10) break;
    end
    check("reached_ctr10", ks_round_ctr, 10);
    rst_n = 1'b0;
    #1;
    check("midrst_keys_ready", keys_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rk_valid", rk_valid, 0);
    check("midrst_ks_start", ks_start, 0);
    check("midrst_ks_round_ctr", ks_round_ctr, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stream_start = 1'b1;
    @(negedge clk);
    stream_start = 1'b0;
    check("stream_in_idle_ignored", rk_valid, 0);
    expand(128'h0, 1'b0);
    run_stream(1'b0);

    // key_schedule that never answers
    ks_hold = 1'b1;
    pulse_start(128'h5555aaaa5555aaaa_5555aaaa5555aaaa);
`ifdef ROUND_KEY_STORE_TIMEOUT_EN
    check("to_ks_start", ks_start, 1);
    n = 0;
    for (cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      n++;
      if (error) break;
    end
    check("timeout_cycles", n, 15);
    check("timeout_busy", busy, 0);
    check("timeout_keys_ready", keys_ready, 0);
    check("timeout_ks_start", ks_start, 0);
    repeat (3) @(negedge clk);
    check("error_sticky", error, 1);
    check("error_idle_busy", busy, 0);
    ks_hold = 1'b0;
    expand(KEY_A, 1'b0);
    check("error_cleared", error, 0);
    run_stream(1'b1);
`else
    n = 0;
    repeat (40) @(negedge clk);
    check("no_timeout_busy", busy, 1);
    check("no_timeout_error", error, 0);
    check("no_timeout_keys_ready", keys_ready, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    ks_hold = 1'b0;
    rst_n = 1'b1;
    expand(KEY_A, 1'b0);
    run_stream(1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
